// File: rtl/frequency_measure_counter.sv
// Gated frequency measurement datapath: synchronises Fx, prescales it by /1, /10 or /100,
// counts events over a fixed gate window and reports over/under-range or a valid result.
module frequency_measure_counter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int CNT_W       = 16,
  parameter int OVER_TH     = 10000,
  parameter int LOW_TH      = 1000
) (
  input  logic             Clk,
  input  logic             Clear_n,
  input  logic             Fx,
  input  logic             reset,
  input  logic [1:0]       std_f_sel,
  output logic             Cntover,
  output logic             Cntlow,
  output logic [CNT_W-1:0] result,
  output logic             result_valid
);

  localparam int TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OVER_CNT   = CNT_W'(OVER_TH);
  localparam logic [CNT_W-1:0]   LOW_CNT    = CNT_W'(LOW_TH);

  typedef enum logic [1:0] {CLR, GATE, EVAL} state_t;
  typedef enum logic [1:0] {DIV100, DIV10, DIV1} div_t;

  state_t             state;
  state_t             next_state;
  div_t               div;
  logic               fx_s1;
  logic               fx_s2;
  logic               fx_d;
  logic               fx_edge;
  logic [6:0]         presc;
  logic [6:0]         presc_last;
  logic               presc_event;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   count;

  // Two-flop synchroniser followed by a registered rising-edge detect.
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      fx_s1   <= 1'b0;
      fx_s2   <= 1'b0;
      fx_d    <= 1'b0;
      fx_edge <= 1'b0;
    end else begin
      fx_s1   <= Fx;
      fx_s2   <= fx_s1;
      fx_d    <= fx_s2;
      fx_edge <= fx_s2 & ~fx_d;
    end
  end

  // The divisor only follows std_f_sel while cleared, so a range change never splits a gate.
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      div <= DIV10;
    end else if (state == CLR) begin
      case (std_f_sel)
        2'b00:   div <= DIV100;
        2'b01:   div <= DIV10;
        default: div <= DIV1;
      endcase
    end
  end

  always_comb begin
    presc_last = 7'd0;
    case (div)
      DIV100:  presc_last = 7'd99;
      DIV10:   presc_last = 7'd9;
      default: presc_last = 7'd0;
    endcase
  end

  assign presc_event = fx_edge && (presc == presc_last);

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state <= CLR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      CLR: begin
        if (!reset) next_state = GATE;
      end
      GATE: begin
        if (reset) begin
          next_state = CLR;
        end else if (timer == TIMER_LAST) begin
          next_state = EVAL;
        end
      end
      EVAL: begin
        next_state = reset ? CLR : GATE;
      end
      default: begin
        next_state = CLR;
      end
    endcase
  end

  // Flags are registered out of EVAL, so they appear exactly one cycle after it.
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      timer        <= '0;
      presc        <= '0;
      count        <= '0;
      result       <= '0;
      Cntover      <= 1'b0;
      Cntlow       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      Cntover      <= 1'b0;
      Cntlow       <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        GATE: begin
          timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
          if (fx_edge) begin
            presc <= (presc == presc_last) ? 7'd0 : presc + 7'd1;
          end
          if (presc_event && (count < OVER_CNT)) begin
            count <= count + 1'b1;
          end
        end
        EVAL: begin
          timer <= '0;
          presc <= '0;
          count <= '0;
          if (count >= OVER_CNT) begin
            Cntover <= 1'b1;
          end else if (count < LOW_CNT) begin
            Cntlow <= 1'b1;
          end else begin
            result       <= count;
            result_valid <= 1'b1;
          end
        end
        default: begin
          timer <= '0;
          presc <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/frequency_measure_counter.md
Name: frequency_measure_counter

Overview:
- Gated measurement datapath for the frequency meter. Counts rising edges of the unknown input Fx during a fixed gate window, after a range prescaler of /1, /10 or /100 selected by std_f_sel.
- Reports out-of-range counts to the range-control FSM as one-cycle Cntover/Cntlow pulses. The FSM answers by re-asserting reset and changing std_f_sel.
- Latches in-range counts into result for the display path.

Parameters:
GATE_CYCLES, 1000000, gate window length in Clk cycles (1 s at 1 MHz)
CNT_W, 16, width of event counter and result
OVER_TH, 10000, count at/above which Cntover fires (counter saturates here)
LOW_TH, 1000, count below which Cntlow fires

Ports:
Clk  input  1  system clock, rising edge
Clear_n  input  1  asynchronous active-low reset
Fx  input  1  signal under test, asynchronous to Clk
reset  input  1  measurement clear from range-control FSM, 1 = hold in clear
std_f_sel  input  2  prescale select: 00 = /100, 01 = /10, 11 = /1, 10 = /1
Cntover  output  1  one-cycle pulse, gate count >= OVER_TH
Cntlow  output  1  one-cycle pulse, gate count < LOW_TH
result  output  CNT_W  last in-range gate count
result_valid  output  1  one-cycle pulse when result updates

Behaviour:
Reset (Clear_n = 0, async):
- FSM goes to CLR.
- Cntover, Cntlow, result_valid, result, counter, prescaler, gate timer and sync flops all go to 0.
- Registered divisor goes to /10.

Fx input conditioning:
- Fx passes through a 2-flop synchroniser, then a rising-edge detect register.
- A counted edge is registered 3 Clk cycles after Fx rises.
- Fx high and low times must each be >= 2 Clk periods.

Prescaler:
- Counts detected edges modulo N and emits one event when it wraps from N-1 to 0 (N = 1 passes every edge).
- std_f_sel is registered into the divisor only while in CLR. Changes during GATE are ignored until the next CLR.

FSM states: CLR, GATE, EVAL.
- CLR: gate timer, prescaler and counter held at 0; flags low. Leave for GATE on the first cycle with reset = 0.
- GATE: timer counts 0..GATE_CYCLES-1; each prescaler event increments the counter. The counter saturates at OVER_TH and never wraps. After the cycle with timer = GATE_CYCLES-1, go to EVAL. Window is exactly GATE_CYCLES cycles.
- EVAL (1 cycle): compare the final count and register the flags. Clear counter, prescaler and timer. Go to GATE (auto-restart), or to CLR if reset = 1.

Evaluation and flag timing:
- Flags are high for exactly the one cycle after EVAL; at most one flag is high per evaluation.
- count >= OVER_TH: Cntover = 1.
- count < LOW_TH: Cntlow = 1.
- Otherwise: result <= count and result_valid = 1.
- Cntover and Cntlow pulses never update result.

Boundary conditions:
- reset = 1 in any state forces CLR on the next edge. An in-progress gate is discarded; no flag, no result_valid; result holds.
- reset = 1 in the same cycle as EVAL: flags from that EVAL are still issued; next state is CLR.
- Prescaler event in the last GATE cycle is counted. An event in EVAL is dropped.
- count = LOW_TH gives valid; count = LOW_TH-1 gives Cntlow; count = OVER_TH gives Cntover.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
Common setup for all scenarios: GATE_CYCLES = 10000, OVER_TH = 1000, LOW_TH = 100, Clk = 10 ns.
1. In-range: Fx period 50 ns, std_f_sel = 01, reset pulsed 2 cycles then 0 -> after 10000 GATE cycles, result_valid pulses once with result = 200±1, both flags 0. A second gate repeats automatically.
2. Cntlow: Fx period 50 ns, std_f_sel = 00 -> count 20±1; Cntlow high exactly 1 cycle, result unchanged.
3. Cntover with saturation: Fx period 50 ns, std_f_sel = 11 -> counter stops at 1000; Cntover 1 cycle after EVAL; result unchanged.
4. Threshold edges: Fx period chosen for exactly 100, then 99 events per gate (sel = 11, Fx period 1000 ns, then 1010 ns) -> result_valid with result = 100, then Cntlow.
5. Abort: reset = 1 at gate cycle 5000 -> no flag or result_valid in that window; state CLR. std_f_sel changed during GATE is ignored until CLR.
6. Async reset: Clear_n = 0 mid-GATE, off Clk edge -> all outputs 0 immediately. After release, the block waits in CLR until reset = 0.
